regfile_wport_arbiter: RTL

REGFILE_WPORT_ARBITER -- requirements
Module: regfile_wport_arbiter

---
 rtl/regfile_wport_arbiter_pkg.sv | 30 +++
 rtl/regfile_wport_arbiter_fifo.sv | 101 ++++++++++
 rtl/regfile_wport_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wport_arbiter_pkg
// Shared CPU definitions for the register-file write-port arbiter:
//   REG_IDX_W / DATA_W / NUM_REGS : register index width, data width, count
//   reg_idx_t / data_t            : convenience types for the above
//   fifo_entry_t                  : one buffered MDU result {valid, rd, data}
//   rd_writes()                   : true when a destination index really
//                                   writes the register file (x0 never does)
// ---------------------------------------------------------------------------
package regfile_wport_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        data_t    data;
    } fifo_entry_t;

    // Register 0 is hard-wired, so a write aimed at it is no write at all.
    function automatic logic rd_writes(input reg_idx_t rd);
        return (rd != '0);
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// mdu_result_fifo
// Small shift-style buffer of multiply/divide results waiting for the
// register-file write port. Slot 0 is always the head; a pop shifts the
// remaining entries down by one.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   push_i/_rd_i/_data_i : append a result behind the surviving entries
//   pop_i             : drop the head (written or already invalidated)
//   kill_en_i/kill_rd_i : clear the valid bit of every entry with rd==kill_rd
//   head_o            : current head record
//   occupancy_o       : number of occupied slots (valid or invalidated)
//   entry_valid_o     : per-slot valid bits
//   entry_rd_o        : per-slot destination register
// ---------------------------------------------------------------------------
module mdu_result_fifo
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  reg_idx_t               push_rd_i,
    input  data_t                  push_data_i,
    input  logic                   pop_i,
    input  logic                   kill_en_i,
    input  reg_idx_t               kill_rd_i,
    output fifo_entry_t            head_o,
    output logic [OCC_W-1:0]       occupancy_o,
    output logic [DEPTH-1:0]       entry_valid_o,
    output reg_idx_t [DEPTH-1:0]   entry_rd_o
);

    fifo_entry_t       slots_q [DEPTH];
    fifo_entry_t       slots_d [DEPTH];
    fifo_entry_t       killed  [DEPTH];
    fifo_entry_t       shifted [DEPTH];
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic [OCC_W-1:0]  occ_after_pop;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_out
            assign entry_valid_o[gi] = slots_q[gi].valid;
            assign entry_rd_o[gi]    = slots_q[gi].rd;
        end
    endgenerate

    assign head_o      = slots_q[0];
    assign occupancy_o = occ_q;

    always_comb begin
        // An invalidated entry keeps its slot until it reaches the head and
        // is popped; only its valid bit is cleared here.
        for (int i = 0; i < DEPTH; i++) begin
            killed[i] = slots_q[i];
            if (kill_en_i && slots_q[i].valid && (slots_q[i].rd == kill_rd_i)) begin
                killed[i].valid = 1'b0;
            end
        end

        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = killed[i + 1];
        end
        shifted[DEPTH-1] = '0;

        occ_after_pop = occ_q - OCC_W'(pop_i);

        // A push lands right behind whatever survives the pop, so a
        // same-cycle pop+push keeps arrival order.
        for (int i = 0; i < DEPTH; i++) begin
            slots_d[i] = pop_i ? shifted[i] : killed[i];
            if (push_i && (occ_after_pop == OCC_W'(i))) begin
                slots_d[i].valid = 1'b1;
                slots_d[i].rd    = push_rd_i;
                slots_d[i].data  = push_data_i;
            end
        end

        occ_d = occ_after_pop + OCC_W'(push_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wport_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage and the multiply/divide unit. WB normally wins; MDU results that
// cannot be written immediately wait in mdu_result_fifo. A starve counter
// forces the buffered head through after STARVE_LIMIT consecutive WB wins,
// stalling WB for that cycle. A WB write kills older buffered results to the
// same register so they can never overwrite the younger value.
//
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   wb_valid/wb_rd/wb_data           : writeback request (rd 0 = no request)
//   wb_stall                         : WB must hold this cycle (forced MDU)
//   mdu_valid/mdu_rd/mdu_data        : MDU result offer
//   mdu_ready                        : MDU result accepted when valid&&ready
//   regWrite/WriteRegister/WriteData : register-file write port (combinational)
//   pending_mask                     : bit n set while a valid buffered
//                                      write to register n exists
// ---------------------------------------------------------------------------
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_IDX_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  wb_stall,
    input  logic                  mdu_valid,
    input  logic [REG_IDX_W-1:0]  mdu_rd,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    output logic                  regWrite,
    output logic [REG_IDX_W-1:0]  WriteRegister,
    output logic [DATA_W-1:0]     WriteData,
    output logic [NUM_REGS-1:0]   pending_mask
);

    localparam int               OCC_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [2:0]       STARVE_AT = 3'(STARVE_LIMIT);

    fifo_entry_t                 head;
    logic [OCC_W-1:0]            occupancy;
    logic [FIFO_DEPTH-1:0]       entry_valid;
    reg_idx_t [FIFO_DEPTH-1:0]   entry_rd;

    logic [2:0] starve_q;
    logic [2:0] starve_d;

    logic wb_req;
    logic forced;
    logic wb_grant;
    logic head_grant;
    logic fifo_empty;
    logic any_valid;
    logic cut_through;
    logic mdu_accept;
    logic push;
    logic pop;

    // -----------------------------------------------------------------------
    // Grant decision
    // -----------------------------------------------------------------------
    assign wb_req     = wb_valid && rd_writes(wb_rd);
    assign fifo_empty = (occupancy == '0);
    assign any_valid  = |entry_valid;

    // Forcing needs a valid head to write; an invalidated head is popped
    // silently and the next entry becomes eligible one cycle later.
    assign forced     = wb_valid && head.valid && (starve_q == STARVE_AT);
    assign wb_grant   = wb_req && !forced;
    assign head_grant = !wb_grant && head.valid;
    // Bypass only when nothing is buffered at all, so results never pass an
    // older entry still sitting in the buffer.
    assign cut_through = !wb_grant && fifo_empty && mdu_valid;

    assign mdu_ready  = (occupancy < OCC_FULL);
    assign mdu_accept = mdu_valid && mdu_ready;
    assign push       = mdu_accept && !cut_through && rd_writes(mdu_rd);
    assign pop        = !fifo_empty && (head_grant || !head.valid);

    // -----------------------------------------------------------------------
    // Write port
    // -----------------------------------------------------------------------
    always_comb begin
        regWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        if (wb_grant) begin
            regWrite      = 1'b1;
            WriteRegister = wb_rd;
            WriteData     = wb_data;
        end else if (head_grant) begin
            regWrite      = 1'b1;
            WriteRegister = head.rd;
            WriteData     = head.data;
        end else if (cut_through) begin
            regWrite      = rd_writes(mdu_rd);
            WriteRegister = mdu_rd;
            WriteData     = mdu_data;
        end
        // Request inputs are ignored entirely while reset is held.
        if (reset) begin
            regWrite = 1'b0;
        end
    end

    assign wb_stall = forced && !reset;

    // -----------------------------------------------------------------------
    // Starve counter
    // -----------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (!any_valid || head_grant) begin
            starve_d = '0;
        end else if (wb_grant && (starve_q != STARVE_AT)) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // -----------------------------------------------------------------------
    // Result buffer
    // -----------------------------------------------------------------------
    mdu_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (push),
        .push_rd_i     (mdu_rd),
        .push_data_i   (mdu_data),
        .pop_i         (pop),
        .kill_en_i     (wb_grant),
        .kill_rd_i     (wb_rd),
        .head_o        (head),
        .occupancy_o   (occupancy),
        .entry_valid_o (entry_valid),
        .entry_rd_o    (entry_rd)
    );

    // -----------------------------------------------------------------------
    // Pending mask: one OR-reduction of slot hits per architectural register
    // -----------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_mask
            logic [FIFO_DEPTH-1:0] hit;
            for (gj = 0; gj < FIFO_DEPTH; gj++) begin : g_slot
                assign hit[gj] = entry_valid[gj] && (entry_rd[gj] == REG_IDX_W'(gi));
            end
            assign pending_mask[gi] = |hit;
        end
    endgenerate

endmodule
